mem_readout_fsm: RTL and testbench

Read-side controller for the capture BRAM. Once the write FSM reports a full memory, this block reads every stored word in address order. It presents each word to a downstream byte consumer, such as the UART transmitter, over a valid/ready handshake. It then pulses done so capture can be re-armed.

---
 rtl/mem_readout_fsm_pkg.sv | 15 +
 rtl/mem_readout_fsm_read_addr_counter.sv | 30 +++
 rtl/mem_readout_fsm.sv | 136 +++++++++++++
 tb/tb_mem_readout_fsm.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_readout_fsm_pkg.sv
// Shared definitions for the capture BRAM read and write controllers.
package mem_readout_fsm_pkg;

   localparam int unsigned ADDR_W_DEF = 10;
   localparam int unsigned DATA_W_DEF = 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      LATCH   = 3'd2,
      PRESENT = 3'd3,
      DONE    = 3'd4
   } state_t;

endpackage

// File: rtl/mem_readout_fsm_read_addr_counter.sv
// Read address counter. It counts from 0 to DEPTH-1 and saturates at
// DEPTH-1, so DEPTH == 2**ADDR_W ends on the all-ones address with no wrap.
module read_addr_counter #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DEPTH  = 1024
) (
   input  logic              clk,
   input  logic              i_rst,
   input  logic              clear,
   input  logic              increment,
   output logic [ADDR_W-1:0] count,
   output logic              is_last
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   assign is_last = (count == LAST);

   // Address register: clear wins over increment; the counter holds at the last address.
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (increment && !is_last) begin
         count <= count + ADDR_W'(1);
      end
   end

endmodule

// File: rtl/mem_readout_fsm.sv
// Capture BRAM readout controller. It reads every stored word in address
// order and streams each word over a valid/ready handshake. After the last
// word is accepted, it pulses done.
module mem_readout_fsm
   import mem_readout_fsm_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned DEPTH  = 1024
) (
   input  logic              clk,
   input  logic              i_rst,
   input  logic              i_start,
   output logic              o_read_ena,
   output logic [ADDR_W-1:0] o_read_addr,
   input  logic [DATA_W-1:0] i_read_data,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic              o_busy,
   output logic              o_done
);

   state_t            state;
   state_t            next_state;
   logic              read_ena_next;
   logic              valid_next;
   logic              busy_next;
   logic              done_next;
   logic              load_data;
   logic              clear_data;
   logic              clear;
   logic              increment;
   logic [ADDR_W-1:0] count;
   logic              is_last;

   read_addr_counter #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_read_addr_counter (
      .clk       (clk),
      .i_rst     (i_rst),
      .clear     (clear),
      .increment (increment),
      .count     (count),
      .is_last   (is_last)
   );

   // The counter is already a register, so the address output comes straight from it.
   assign o_read_addr = count;

   // Next-state and next-output decode. The outputs are computed for the state
   // being entered and then registered, so each output lines up with its state.
   always_comb begin
      next_state    = state;
      read_ena_next = 1'b0;
      valid_next    = o_valid;
      busy_next     = 1'b1;
      done_next     = 1'b0;
      load_data     = 1'b0;
      clear_data    = 1'b0;
      clear         = 1'b0;
      increment     = 1'b0;
      case (state)
         IDLE: begin
            clear      = 1'b1;
            valid_next = 1'b0;
            if (i_start) begin
               next_state    = FETCH;
               read_ena_next = 1'b1;
            end else begin
               busy_next = 1'b0;
            end
         end
         FETCH: begin
            next_state = LATCH;
            valid_next = 1'b0;
         end
         LATCH: begin
            next_state = PRESENT;
            load_data  = 1'b1;
            valid_next = 1'b1;
         end
         PRESENT: begin
            if (o_valid && i_ready) begin
               valid_next = 1'b0;
               if (is_last) begin
                  next_state = DONE;
                  done_next  = 1'b1;
               end else begin
                  next_state    = FETCH;
                  increment     = 1'b1;
                  read_ena_next = 1'b1;
               end
            end
         end
         DONE: begin
            next_state = IDLE;
            clear      = 1'b1;
            valid_next = 1'b0;
            busy_next  = 1'b0;
         end
         default: begin
            next_state = IDLE;
            clear      = 1'b1;
            clear_data = 1'b1;
            valid_next = 1'b0;
            busy_next  = 1'b0;
         end
      endcase
   end

   // State register and registered outputs, with asynchronous return to the reset values.
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= IDLE;
         o_read_ena <= 1'b0;
         o_data     <= '0;
         o_valid    <= 1'b0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
      end else begin
         state      <= next_state;
         o_read_ena <= read_ena_next;
         o_valid    <= valid_next;
         o_busy     <= busy_next;
         o_done     <= done_next;
         if (clear_data) begin
            o_data <= '0;
         end else if (load_data) begin
            o_data <= i_read_data;
         end
      end
   end

endmodule

// File: tb/tb_mem_readout_fsm.sv
// Directed bench for mem_readout_fsm: DUT a (DEPTH=4) and DUT b (ADDR_W=3, DEPTH=8).
module tb_mem_readout_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_a;
   logic       start_b;
   logic       ready;
   logic       sel;

   logic       ren_a, ren_b, valid_a, valid_b, busy_a, busy_b, done_a, done_b;
   logic [9:0] addr_a;
   logic [2:0] addr_b;
   logic [7:0] rdata_a, rdata_b, data_a, data_b;

   logic       o_ren, o_valid, o_busy, o_done;
   logic [9:0] o_addr;
   logic [7:0] o_data;

   int unsigned errors = 0;
   int unsigned checks = 0;
   int unsigned reads  = 0;

   always #5 clk = ~clk;

   mem_readout_fsm #(
      .ADDR_W (10),
      .DATA_W (8),
      .DEPTH  (4)
   ) dut_a (
      .clk         (clk),
      .i_rst       (rst),
      .i_start     (start_a),
      .o_read_ena  (ren_a),
      .o_read_addr (addr_a),
      .i_read_data (rdata_a),
      .o_data      (data_a),
      .o_valid     (valid_a),
      .i_ready     (ready),
      .o_busy      (busy_a),
      .o_done      (done_a)
   );

   mem_readout_fsm #(
      .ADDR_W (3),
      .DATA_W (8),
      .DEPTH  (8)
   ) dut_b (
      .clk         (clk),
      .i_rst       (rst),
      .i_start     (start_b),
      .o_read_ena  (ren_b),
      .o_read_addr (addr_b),
      .i_read_data (rdata_b),
      .o_data      (data_b),
      .o_valid     (valid_b),
      .i_ready     (ready),
      .o_busy      (busy_b),
      .o_done      (done_b)
   );

   // BRAM models with 1-cycle read latency: a holds A0..A3, b holds 5C + 3*addr.
   always @(posedge clk) begin
      if (ren_a) rdata_a <= 8'hA0 + addr_a[7:0];
      if (ren_b) rdata_b <= 8'h5C + {5'd0, addr_b} * 8'd3;
   end

   assign o_ren   = sel ? ren_b   : ren_a;
   assign o_valid = sel ? valid_b : valid_a;
   assign o_busy  = sel ? busy_b  : busy_a;
   assign o_done  = sel ? done_b  : done_a;
   assign o_addr  = sel ? {7'd0, addr_b} : addr_a;
   assign o_data  = sel ? data_b  : data_a;

   // Count the BRAM read strobes of the selected DUT.
   always @(posedge clk) begin
      if (o_ren) reads <= reads + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_start(input logic v);
      if (sel) start_b = v;
      else start_a = v;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_values();
      chk("rst_ren", o_ren, 1'b0);
      chk("rst_addr", o_addr, 0);
      chk("rst_data", o_data, 0);
      chk("rst_valid", o_valid, 1'b0);
      chk("rst_busy", o_busy, 1'b0);
      chk("rst_done", o_done, 1'b0);
   endtask

   // Entry point: just after the edge that entered FETCH for word w.
   task automatic word_step(input int unsigned w, input int unsigned hold, input bit poke);
      logic [7:0] e;
      e = sel ? 8'(8'h5C + w * 3) : 8'(8'hA0 + w);
      chk("fetch_ren", o_ren, 1'b1);
      chk("fetch_addr", o_addr, w);
      chk("fetch_valid", o_valid, 1'b0);
      chk("fetch_busy", o_busy, 1'b1);
      chk("fetch_done", o_done, 1'b0);
      tick();
      chk("latch_ren", o_ren, 1'b0);
      chk("latch_valid", o_valid, 1'b0);
      tick();
      chk("present_valid", o_valid, 1'b1);
      chk("present_data", o_data, e);
      chk("present_addr", o_addr, w);
      chk("present_ren", o_ren, 1'b0);
      if (hold > 0) begin
         ready = 1'b0;
         for (int unsigned i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", o_valid, 1'b1);
            chk("hold_data", o_data, e);
            chk("hold_addr", o_addr, w);
            chk("hold_ren", o_ren, 1'b0);
         end
         ready = 1'b1;
      end
      if (poke) begin
         set_start(1'b1);
         tick();
         set_start(1'b0);
      end else begin
         tick();
      end
   endtask

   // Entry point: FETCH of word 0. Exit point: the DONE cycle.
   task automatic readout(input int unsigned depth, input int unsigned hold_word,
                          input int unsigned hold_n, input int unsigned poke_word);
      int unsigned r0;
      r0 = reads;
      for (int unsigned w = 0; w < depth; w++) begin
         word_step(w, (w == hold_word) ? hold_n : 0, w == poke_word);
      end
      chk("done_pulse", o_done, 1'b1);
      chk("done_valid", o_valid, 1'b0);
      chk("done_busy", o_busy, 1'b1);
      chk("read_count", reads - r0, depth);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, o_busy, 1'b0);
      chk({tag, "_done"}, o_done, 1'b0);
      chk({tag, "_ren"}, o_ren, 1'b0);
      chk({tag, "_valid"}, o_valid, 1'b0);
   endtask

   initial begin
      rst     = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      ready   = 1'b1;
      sel     = 1'b0;
      tick();
      tick();
      chk_reset_values();
      sel = 1'b1;
      chk_reset_values();
      sel = 1'b0;
      rst = 1'b0;
      tick();

      // Plain readout of four words with ready high.
      set_start(1'b1);
      tick();
      set_start(1'b0);
      readout(4, 99, 0, 99);
      tick();
      chk_idle("t1_idle");
      tick();
      chk_idle("t1_idle2");

      // Backpressure on word 1 for five cycles.
      set_start(1'b1);
      tick();
      set_start(1'b0);
      readout(4, 1, 5, 99);
      tick();
      chk_idle("t2_idle");

      // A start pulse during the PRESENT state of word 2 is ignored.
      set_start(1'b1);
      tick();
      set_start(1'b0);
      readout(4, 99, 0, 2);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_idle("t3_after");
      end

      // Asynchronous reset during LATCH of word 2, then a restart from address 0.
      set_start(1'b1);
      tick();
      set_start(1'b0);
      word_step(0, 0, 1'b0);
      word_step(1, 0, 1'b0);
      chk("t4_fetch_addr", o_addr, 2);
      tick();
      chk("t4_latch_ren", o_ren, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk_reset_values();
      tick();
      rst = 1'b0;
      tick();
      chk_idle("t4_idle");
      tick();
      chk_idle("t4_idle2");
      set_start(1'b1);
      tick();
      set_start(1'b0);
      readout(4, 99, 0, 99);
      tick();
      chk_idle("t4_end");

      // Full address space of DUT b: 0..7 each read once, no wrap.
      sel = 1'b1;
      set_start(1'b1);
      tick();
      set_start(1'b0);
      readout(8, 99, 0, 99);
      tick();
      chk_idle("t5_idle");
      chk("t5_addr_cleared", o_addr, 0);
      tick();
      chk_idle("t5_idle2");
      sel = 1'b0;

      // Start held high: back-to-back readouts with one IDLE cycle between them.
      set_start(1'b1);
      tick();
      readout(4, 99, 0, 99);
      tick();
      chk_idle("t6_gap");
      tick();
      set_start(1'b0);
      readout(4, 99, 0, 99);
      tick();
      chk_idle("t6_end");
      tick();
      chk_idle("t6_end2");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
